// File: rtl/sys_bridge.sv
// rtl/sys_bridge.sv - CPU/IO bridge responder: two timers, output register, synchronised input port
//
// sys_bridge ports:
//   clk, rst       clock, asynchronous active-high reset
//   PrAddr[29:0]   CPU word address (byte address bits [31:2])
//   PrWD, PrBE     write data and per-byte enables
//   IOWrite        one-cycle write strobe
//   PrRD           combinational read data for PrAddr
//   HWInt[7:2]     interrupt lines to CP0 ([2] timer0, [3] timer1)
//   dev_in         asynchronous external input
//   dev_out        output device register
//
// sys_bridge_timer ports:
//   wr_ctrl_i, wr_preset_i   write strobes for CTRL / PRESET
//   wd_i, wmask_i            write data and expanded byte mask
//   ctrl_o, preset_o, count_o, irq_o   register views and masked interrupt

module sys_bridge_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_ctrl_i,
    input  logic        wr_preset_i,
    input  logic [31:0] wd_i,
    input  logic [31:0] wmask_i,
    output logic [3:0]  ctrl_o,
    output logic [31:0] preset_o,
    output logic [31:0] count_o,
    output logic        irq_o
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INTR} state_t;

    state_t      state_q;
    logic [3:0]  ctrl_q;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q;
    logic        pending_q;
    logic        en, auto_reload;

    assign en          = ctrl_q[0];
    assign auto_reload = (ctrl_q[2:1] == 2'b01);
    assign preset_d    = (preset_q & ~wmask_i) | (wd_i & wmask_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ctrl_q    <= 4'b0;
            preset_q  <= 32'b0;
            count_q   <= 32'b0;
            pending_q <= 1'b0;
        end else begin
            if (wr_preset_i)
                preset_q <= preset_d;
            if (wr_ctrl_i)
                pending_q <= 1'b0;

            case (state_q)
                IDLE: if (en) state_q <= LOAD;
                LOAD: begin
                    if (!en) begin
                        state_q <= IDLE;
                    end else begin
                        count_q <= preset_q;
                        state_q <= CNT;
                    end
                end
                CNT: begin
                    if (!en) begin
                        state_q <= IDLE;
                    end else if (count_q > 32'd1) begin
                        count_q <= count_q - 32'd1;
                    end else begin
                        // PRESET of 0 or 1 both expire here
                        count_q <= 32'b0;
                        state_q <= INTR;
                    end
                end
                INTR: begin
                    if (!en) begin
                        state_q <= IDLE;
                    end else if (auto_reload) begin
                        state_q <= LOAD;
                    end else begin
                        ctrl_q[0] <= 1'b0;
                        // a CTRL write in this cycle clears the pending flag instead
                        if (!wr_ctrl_i)
                            pending_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // placed last so a CPU write of En overrides the one-shot auto-clear
            if (wr_ctrl_i && wmask_i[0])
                ctrl_q <= wd_i[3:0];
        end
    end

    assign ctrl_o   = ctrl_q;
    assign preset_o = preset_q;
    assign count_o  = count_q;
    assign irq_o    = ctrl_q[3] & (pending_q | (state_q == INTR));
endmodule

module sys_bridge #(
    parameter logic [31:0] TIMER0_BASE = 32'h0000_7F00,
    parameter logic [31:0] TIMER1_BASE = 32'h0000_7F10,
    parameter logic [31:0] OUT_ADDR    = 32'h0000_7F20,
    parameter logic [31:0] IN_ADDR     = 32'h0000_7F24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] PrAddr,
    input  logic [31:0] PrWD,
    input  logic [3:0]  PrBE,
    input  logic        IOWrite,
    output logic [31:0] PrRD,
    output logic [7:2]  HWInt,
    input  logic [31:0] dev_in,
    output logic [31:0] dev_out
);
    logic [31:0] wmask;
    logic [29:0] off0, off1;
    logic        t0_hit, t1_hit, out_hit, in_hit;
    logic [31:0] out_q, out_d;
    logic [31:0] sync1_q, sync2_q;
    logic [3:0]  ctrl0, ctrl1;
    logic [31:0] preset0, preset1, count0, count1;
    logic        irq0, irq1;

    assign wmask = {{8{PrBE[3]}}, {8{PrBE[2]}}, {8{PrBE[1]}}, {8{PrBE[0]}}};

    // decode in word units; bases are word aligned
    assign off0    = PrAddr - TIMER0_BASE[31:2];
    assign off1    = PrAddr - TIMER1_BASE[31:2];
    assign t0_hit  = (off0 < 30'd3);
    assign t1_hit  = (off1 < 30'd3);
    assign out_hit = (PrAddr == OUT_ADDR[31:2]);
    assign in_hit  = (PrAddr == IN_ADDR[31:2]);

    sys_bridge_timer u_timer0 (
        .clk         (clk),
        .rst         (rst),
        .wr_ctrl_i   (IOWrite && t0_hit && off0[1:0] == 2'd0),
        .wr_preset_i (IOWrite && t0_hit && off0[1:0] == 2'd1),
        .wd_i        (PrWD),
        .wmask_i     (wmask),
        .ctrl_o      (ctrl0),
        .preset_o    (preset0),
        .count_o     (count0),
        .irq_o       (irq0)
    );

    sys_bridge_timer u_timer1 (
        .clk         (clk),
        .rst         (rst),
        .wr_ctrl_i   (IOWrite && t1_hit && off1[1:0] == 2'd0),
        .wr_preset_i (IOWrite && t1_hit && off1[1:0] == 2'd1),
        .wd_i        (PrWD),
        .wmask_i     (wmask),
        .ctrl_o      (ctrl1),
        .preset_o    (preset1),
        .count_o     (count1),
        .irq_o       (irq1)
    );

    assign out_d = (out_q & ~wmask) | (PrWD & wmask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= 32'b0;
            sync1_q <= 32'b0;
            sync2_q <= 32'b0;
        end else begin
            if (IOWrite && out_hit)
                out_q <= out_d;
            sync1_q <= dev_in;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        PrRD = 32'b0;
        if (t0_hit) begin
            case (off0[1:0])
                2'd0:    PrRD = {28'b0, ctrl0};
                2'd1:    PrRD = preset0;
                default: PrRD = count0;
            endcase
        end else if (t1_hit) begin
            case (off1[1:0])
                2'd0:    PrRD = {28'b0, ctrl1};
                2'd1:    PrRD = preset1;
                default: PrRD = count1;
            endcase
        end else if (out_hit) begin
            PrRD = out_q;
        end else if (in_hit) begin
            PrRD = sync2_q;
        end
    end

    assign dev_out = out_q;
    assign HWInt   = {4'b0, irq1, irq0};
endmodule

// File: tb/tb_sys_bridge.sv
// tb/tb_sys_bridge.sv - self-checking bench for sys_bridge

module tb_sys_bridge;
    localparam logic [31:0] T0 = 32'h7F00;
    localparam logic [31:0] T1 = 32'h7F10;
    localparam logic [31:0] OA = 32'h7F20;
    localparam logic [31:0] IA = 32'h7F24;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] PrAddr;
    logic [31:0] PrWD;
    logic [3:0]  PrBE;
    logic        IOWrite;
    logic [31:0] PrRD;
    logic [7:2]  HWInt;
    logic [31:0] dev_in;
    logic [31:0] dev_out;

    int total = 0;
    int bad   = 0;

    sys_bridge dut (
        .clk     (clk),
        .rst     (rst),
        .PrAddr  (PrAddr),
        .PrWD    (PrWD),
        .PrBE    (PrBE),
        .IOWrite (IOWrite),
        .PrRD    (PrRD),
        .HWInt   (HWInt),
        .dev_in  (dev_in),
        .dev_out (dev_out)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        PrAddr  = addr[31:2];
        PrWD    = data;
        PrBE    = be;
        IOWrite = 1'b1;
        tick();
        IOWrite = 1'b0;
        PrBE    = 4'hF;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        PrAddr = addr[31:2];
        #1;
        data = PrRD;
    endtask

    // reference timer behaviour, k = edges since the En write
    function automatic int exp_count(int k, int n);
        if (k >= 2 && k <= n + 1) return n - (k - 2);
        return 0;
    endfunction

    function automatic logic oneshot_irq(int k, int n);
        int eff = (n == 0) ? 1 : n;
        return (k >= eff + 2);
    endfunction

    function automatic logic auto_irq(int k, int n);
        int eff = (n == 0) ? 1 : n;
        return (k >= eff + 2) && ((k - (eff + 2)) % (eff + 2) == 0);
    endfunction

    task automatic run_oneshot(input int n, input logic im);
        logic [31:0] v;
        wr(T0 + 4, n, 4'hF);
        wr(T0, {28'b0, im, 3'b001}, 4'hF);
        for (int k = 1; k <= n + 5; k++) begin
            tick();
            rd(T0 + 8, v);
            chk($sformatf("os_count n=%0d k=%0d", n, k), v, exp_count(k, n));
            chk($sformatf("os_irq n=%0d k=%0d", n, k), {31'b0, HWInt[2]}, {31'b0, im & oneshot_irq(k, n)});
        end
        rd(T0, v);
        chk("os_ctrl_en_cleared", v, {28'b0, im, 3'b000});
        wr(T0, 32'h0, 4'hF);
        chk("os_irq_cleared", {31'b0, HWInt[2]}, 32'h0);
    endtask

    initial begin
        logic [31:0] v, model_out, d;
        logic [3:0]  be;
        int          n;

        rst = 1'b1; PrAddr = '0; PrWD = '0; PrBE = 4'hF; IOWrite = 1'b0; dev_in = '0;
        tick();
        rd(T0, v);      chk("rst_ctrl0", v, 32'h0);
        rd(T0 + 4, v);  chk("rst_preset0", v, 32'h0);
        rd(T1 + 8, v);  chk("rst_count1", v, 32'h0);
        chk("rst_hwint", {26'b0, HWInt}, 32'h0);
        chk("rst_devout", dev_out, 32'h0);
        rst = 1'b0;
        tick();

        // one-shot: directed N=5 then random presets (including 0)
        run_oneshot(5, 1'b1);
        for (int i = 0; i < 3; i++) run_oneshot($urandom_range(8, 0), 1'b1);
        run_oneshot($urandom_range(6, 1), 1'b0);

        // timer1 auto-reload, directed N=3 then a random N
        for (int r = 0; r < 2; r++) begin
            n = (r == 0) ? 3 : $urandom_range(6, 1);
            wr(T1 + 4, n, 4'hF);
            wr(T1, 32'hB, 4'hF);
            for (int k = 1; k <= 4 * (n + 2) + 2; k++) begin
                tick();
                chk($sformatf("ar_irq n=%0d k=%0d", n, k), {31'b0, HWInt[3]}, {31'b0, auto_irq(k, n)});
                chk($sformatf("ar_t0 k=%0d", k), {31'b0, HWInt[2]}, 32'h0);
            end
            wr(T1, 32'h0, 4'hF);
            tick();
            chk("ar_stopped", {31'b0, HWInt[3]}, 32'h0);
        end

        // byte-merged output register
        model_out = 32'h0;
        wr(OA, 32'hAABBCCDD, 4'b0101);
        model_out = 32'h00BB00DD;
        chk("out_be_devout", dev_out, model_out);
        rd(OA, v); chk("out_be_read", v, model_out);
        for (int i = 0; i < 8; i++) begin
            d  = $urandom;
            be = 4'($urandom_range(15, 0));
            wr(OA, d, be);
            for (int b = 0; b < 4; b++)
                if (be[b]) model_out[b*8 +: 8] = d[b*8 +: 8];
            chk($sformatf("out_rand%0d", i), dev_out, model_out);
            rd(OA, v); chk($sformatf("out_rand_rd%0d", i), v, model_out);
        end

        // synchroniser latency
        dev_in = 32'h1234;
        rd(IA, v); chk("in_lag0", v, 32'h0);
        tick(); rd(IA, v); chk("in_lag1", v, 32'h0);
        tick(); rd(IA, v); chk("in_new", v, 32'h1234);
        wr(IA, 32'hFFFF_FFFF, 4'hF);
        rd(IA, v); chk("in_write_ignored", v, 32'h1234);

        // unmapped and read-only
        rd(32'h7F30, v); chk("unmapped_rd", v, 32'h0);
        rd(T0 + 12, v);  chk("unmapped_t0_word3", v, 32'h0);
        wr(T0 + 8, 32'hFFFF_FFFF, 4'hF);
        rd(T0 + 8, v);   chk("count_write_ignored", v, 32'h0);

        // reset mid-count
        wr(T0 + 4, 32'd6, 4'hF);
        wr(T0, 32'h9, 4'hF);
        for (int k = 1; k <= 5; k++) tick();
        rd(T0 + 8, v); chk("pre_rst_count", v, 32'd3);
        rst = 1'b1;
        #1;
        rd(T0 + 8, v); chk("midrst_count", v, 32'h0);
        rd(T0, v);     chk("midrst_ctrl", v, 32'h0);
        rd(T0 + 4, v); chk("midrst_preset", v, 32'h0);
        rd(IA, v);     chk("midrst_in", v, 32'h0);
        chk("midrst_devout", dev_out, 32'h0);
        chk("midrst_hwint", {26'b0, HWInt}, 32'h0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk($sformatf("postrst_hwint%0d", k), {26'b0, HWInt}, 32'h0);
        end
        rd(T0 + 8, v); chk("postrst_count", v, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
